// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// VGA 640x480@60 timing generator: 25 MHz pixel enable from a 50 MHz clock, registered syncs/coords.
// Optional RGB332 colour-bar pattern on rgb_o when VGA_PATTERN_EN is defined.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       clk_i,
    input  logic       reset_i,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       video_on_o,
    output logic       pixel_tick_o,
    output logic [9:0] pixel_x_o,
    output logic [9:0] pixel_y_o,
    output logic       frame_start_o
`ifdef VGA_PATTERN_EN
    ,
    output logic [7:0] rgb_o
`endif
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic       r_tick;
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_video_on;
    logic       r_frame_start;

    logic       w_h_wrap;
    logic       w_v_wrap;
    logic [9:0] w_h_next;
    logic [9:0] w_v_next;
    logic       w_hsync;
    logic       w_vsync;
    logic       w_video_on;

    // Decode from the next count values so syncs register on the same edge as the coordinates.
    always_comb begin
        w_h_wrap   = (r_h_cnt == H_LAST);
        w_v_wrap   = (r_v_cnt == V_LAST);
        w_h_next   = w_h_wrap ? '0 : r_h_cnt + 10'd1;
        w_v_next   = r_v_cnt;
        if (w_h_wrap) begin
            w_v_next = w_v_wrap ? '0 : r_v_cnt + 10'd1;
        end
        w_hsync    = !((w_h_next >= H_SYNC_START) && (w_h_next <= H_SYNC_END));
        w_vsync    = !((w_v_next >= V_SYNC_START) && (w_v_next <= V_SYNC_END));
        w_video_on = (w_h_next < H_VIS) && (w_v_next < V_VIS);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_tick        <= 1'b0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_video_on    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_tick <= ~r_tick;
            if (r_tick) begin
                r_h_cnt       <= w_h_next;
                r_v_cnt       <= w_v_next;
                r_hsync       <= w_hsync;
                r_vsync       <= w_vsync;
                r_video_on    <= w_video_on;
                r_frame_start <= w_h_wrap && w_v_wrap;
            end else begin
                r_frame_start <= 1'b0;
            end
        end
    end

    assign hsync_o       = r_hsync;
    assign vsync_o       = r_vsync;
    assign video_on_o    = r_video_on;
    assign pixel_tick_o  = r_tick;
    assign pixel_x_o     = r_h_cnt;
    assign pixel_y_o     = r_v_cnt;
    assign frame_start_o = r_frame_start;

`ifdef VGA_PATTERN_EN
    localparam int unsigned BAR_W = H_VISIBLE / 8;

    logic [2:0] w_bar;
    logic [7:0] w_color;
    logic [7:0] r_rgb;

    always_comb begin
        w_bar = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (w_h_next >= 10'(i * BAR_W)) begin
                w_bar = 3'(i);
            end
        end
        case (w_bar)
            3'd0:    w_color = 8'hFF;
            3'd1:    w_color = 8'hFC;
            3'd2:    w_color = 8'h1F;
            3'd3:    w_color = 8'h1C;
            3'd4:    w_color = 8'hE3;
            3'd5:    w_color = 8'hE0;
            3'd6:    w_color = 8'h03;
            default: w_color = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rgb <= '0;
        end else if (r_tick) begin
            r_rgb <= w_video_on ? w_color : '0;
        end
    end

    assign rgb_o = r_rgb;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Directed bench: default-parameter instance for reset/line/pattern, shrunken instance for frame timing.
module tb_vga_timing_gen;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;

    logic       hsync, vsync, video_on, tick, fs;
    logic [9:0] px, py;
    logic       s_hsync, s_vsync, s_video_on, s_tick, s_fs;
    logic [9:0] s_px, s_py;
`ifdef VGA_PATTERN_EN
    logic [7:0] rgb, s_rgb;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #10 clk_i = ~clk_i;

    vga_timing_gen u_dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .hsync_o       (hsync),
        .vsync_o       (vsync),
        .video_on_o    (video_on),
        .pixel_tick_o  (tick),
        .pixel_x_o     (px),
        .pixel_y_o     (py),
        .frame_start_o (fs)
`ifdef VGA_PATTERN_EN
        ,
        .rgb_o         (rgb)
`endif
    );

    // Small geometry: line 25 px (sync x=18..21), frame 19 lines (sync y=14..15), 950 clk per frame.
    vga_timing_gen #(
        .H_VISIBLE (16), .H_FRONT (2), .H_SYNC (4), .H_BACK (3),
        .V_VISIBLE (12), .V_FRONT (2), .V_SYNC (2), .V_BACK (3)
    ) u_small (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .hsync_o       (s_hsync),
        .vsync_o       (s_vsync),
        .video_on_o    (s_video_on),
        .pixel_tick_o  (s_tick),
        .pixel_x_o     (s_px),
        .pixel_y_o     (s_py),
        .frame_start_o (s_fs)
`ifdef VGA_PATTERN_EN
        ,
        .rgb_o         (s_rgb)
`endif
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        logic [0:3] exp_tick;
        logic [9:0] exp_x [4];
        exp_tick = 4'b1010;
        exp_x    = '{10'd0, 10'd1, 10'd1, 10'd2};
        reset_i = 1'b1;
        repeat (3) step();
        checks++;
        if ({tick, px, py, hsync, vsync, video_on, fs} !== {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got tick=%b x=%0d y=%0d hs=%b vs=%b von=%b fs=%b, want 0 0 0 1 1 0 0",
                     tick, px, py, hsync, vsync, video_on, fs);
        end
        checks++;
        if ({s_tick, s_px, s_py, s_hsync, s_vsync, s_video_on, s_fs} !== {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state_small: got tick=%b x=%0d y=%0d hs=%b vs=%b von=%b fs=%b",
                     s_tick, s_px, s_py, s_hsync, s_vsync, s_video_on, s_fs);
        end
`ifdef VGA_PATTERN_EN
        checks++;
        if (rgb !== 8'h00) begin
            errors++;
            $display("FAIL reset_rgb: got %h want 00", rgb);
        end
`endif
        reset_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (tick !== exp_tick[i] || px !== exp_x[i]) begin
                errors++;
                $display("FAIL release_edge%0d: got tick=%b x=%0d want tick=%b x=%0d",
                         i + 1, tick, px, exp_tick[i], exp_x[i]);
            end
        end
        checks++;
        if (video_on !== 1'b1 || hsync !== 1'b1) begin
            errors++;
            $display("FAIL first_pixels_visible: got von=%b hs=%b want 1 1", video_on, hsync);
        end
    endtask

    task automatic test_line();
        int unsigned n;
        int unsigned low_cnt;
        int unsigned bad;
        n = 0;
        while (!(px == 10'd639 && tick == 1'b0) && n < 3000) begin
            step();
            n++;
        end
        checks++;
        if (px !== 10'd639 || video_on !== 1'b1) begin
            errors++;
            $display("FAIL reach_x639: got x=%0d von=%b want 639 1", px, video_on);
        end
        step();
        step();
        checks++;
        if (px !== 10'd640 || video_on !== 1'b0) begin
            errors++;
            $display("FAIL x640_video_off: got x=%0d von=%b want 640 0", px, video_on);
        end
        low_cnt = 0;
        bad = 0;
        for (int i = 0; i < 1600; i++) begin
            step();
            if (hsync == 1'b0) low_cnt++;
            if (hsync !== !(px >= 10'd656 && px <= 10'd751)) bad++;
            if (video_on !== (px < 10'd640)) bad++;
        end
        checks++;
        if (low_cnt != 192) begin
            errors++;
            $display("FAIL hsync_width: got %0d clk low want 192", low_cnt);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hsync_video_decode: got %0d bad samples want 0", bad);
        end
        checks++;
        if (px !== 10'd640 || py !== 10'd1) begin
            errors++;
            $display("FAIL line_wrap: got x=%0d y=%0d want 640 1", px, py);
        end
    endtask

    task automatic test_frame();
        int unsigned n;
        int unsigned period;
        int unsigned vlow;
        int unsigned bad;
        n = 0;
        while (s_fs !== 1'b1 && n < 2000) begin
            step();
            n++;
        end
        checks++;
        if (s_fs !== 1'b1 || s_px !== 10'd0 || s_py !== 10'd0) begin
            errors++;
            $display("FAIL first_frame_start: got fs=%b x=%0d y=%0d want 1 0 0", s_fs, s_px, s_py);
        end
        period = 0;
        vlow = 0;
        bad = 0;
        for (int i = 1; i <= 2000; i++) begin
            step();
            if (i == 1) begin
                checks++;
                if (s_fs !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_start_width: got fs=%b on 2nd cycle want 0", s_fs);
                end
            end
            if (s_vsync == 1'b0) vlow++;
            if (s_vsync !== !(s_py >= 10'd14 && s_py <= 10'd15)) bad++;
            if (s_hsync !== !(s_px >= 10'd18 && s_px <= 10'd21)) bad++;
            if (s_video_on !== (s_px < 10'd16 && s_py < 10'd12)) bad++;
            if (s_fs === 1'b1) begin
                period = i;
                break;
            end
        end
        checks++;
        if (period != 950) begin
            errors++;
            $display("FAIL frame_period: got %0d clk want 950", period);
        end
        checks++;
        if (vlow != 100) begin
            errors++;
            $display("FAIL vsync_width: got %0d clk low want 100", vlow);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL small_decode: got %0d bad samples want 0", bad);
        end
    endtask

    task automatic test_mid_reset();
        int unsigned n;
        n = 0;
        while (!(s_px == 10'd20 && s_py == 10'd14) && n < 2000) begin
            step();
            n++;
        end
        checks++;
        if (s_hsync !== 1'b0 || s_vsync !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_sync: got hs=%b vs=%b want 0 0 at x=%0d y=%0d", s_hsync, s_vsync, s_px, s_py);
        end
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        checks++;
        if ({s_px, s_py, s_hsync, s_vsync, s_fs, s_tick} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: got x=%0d y=%0d hs=%b vs=%b fs=%b tick=%b want 0 0 1 1 0 0",
                     s_px, s_py, s_hsync, s_vsync, s_fs, s_tick);
        end
        n = 0;
        while (!(s_px == 10'd24 && s_py == 10'd18 && s_tick == 1'b1) && n < 2000) begin
            step();
            n++;
        end
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        checks++;
        if ({s_px, s_py, s_fs, s_tick} !== {10'd0, 10'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_over_wrap: got x=%0d y=%0d fs=%b tick=%b want 0 0 0 0", s_px, s_py, s_fs, s_tick);
        end
        step();
        checks++;
        if (s_tick !== 1'b1 || s_fs !== 1'b0 || s_px !== 10'd0) begin
            errors++;
            $display("FAIL post_reset_edge: got tick=%b fs=%b x=%0d want 1 0 0", s_tick, s_fs, s_px);
        end
    endtask

`ifdef VGA_PATTERN_EN
    task automatic test_pattern();
        int unsigned n;
        int unsigned tx [11];
        logic [7:0]  tv [11];
        tx = '{0, 79, 80, 160, 240, 320, 400, 480, 560, 639, 700};
        tv = '{8'hFF, 8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00, 8'h00, 8'h00};
        n = 0;
        while (!(py == 10'd10 && px == 10'd0 && tick == 1'b0) && n < 20000) begin
            step();
            n++;
        end
        n = 0;
        while (n < 2000) begin
            if (tick == 1'b0) begin
                for (int i = 0; i < 11; i++) begin
                    if (px == 10'(tx[i])) begin
                        checks++;
                        if (rgb !== tv[i] || py !== 10'd10) begin
                            errors++;
                            $display("FAIL rgb_x%0d: got %h (y=%0d) want %h (y=10)", tx[i], rgb, py, tv[i]);
                        end
                    end
                end
            end
            if (px == 10'd700) break;
            step();
            n++;
        end
        checks++;
        if (px !== 10'd700) begin
            errors++;
            $display("FAIL pattern_timeout: got x=%0d want 700", px);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_mid_reset();
`ifdef VGA_PATTERN_EN
        test_pattern();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
